// File: rtl/actividad_03_pkg.sv
// =============================================================================
// Module  : actividad_03_pkg
// Brief   : Op-index constants shared by the gate bank, its register stage and benches
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

package actividad_03_pkg;

  localparam int unsigned c_num_ops = 8;

  // Index of each gate result inside the packed result vector.
  localparam logic [2:0] c_op_and  = 3'd0;
  localparam logic [2:0] c_op_or   = 3'd1;
  localparam logic [2:0] c_op_xor  = 3'd2;
  localparam logic [2:0] c_op_not  = 3'd3;
  localparam logic [2:0] c_op_nand = 3'd4;
  localparam logic [2:0] c_op_yes  = 3'd5;
  localparam logic [2:0] c_op_nor  = 3'd6;
  localparam logic [2:0] c_op_xnor = 3'd7;

endpackage

`default_nettype wire

// File: rtl/actividad_03_gate_bank.sv
// =============================================================================
// Module  : gate_bank
// Brief   : Combinational bank of eight bitwise gates on two WIDTH-bit operands
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module gate_bank
  import actividad_03_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0]                a,
  input  logic [WIDTH-1:0]                b,
  output logic [c_num_ops-1:0][WIDTH-1:0] y
);

  always_comb begin
    y            = '0;
    y[c_op_and]  = a & b;
    y[c_op_or]   = a | b;
    y[c_op_xor]  = a ^ b;
    y[c_op_not]  = ~a;
    y[c_op_nand] = ~(a & b);
    y[c_op_yes]  = a;
    y[c_op_nor]  = ~(a | b);
    y[c_op_xnor] = ~(a ^ b);
  end

endmodule

`default_nettype wire

// File: rtl/actividad_03.sv
// =============================================================================
// Module  : actividad_03
// Brief   : Registered eight-gate bank, one cycle latency, synchronous clear to zero
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module actividad_03
  import actividad_03_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] entrada1,
  input  logic [WIDTH-1:0] entrada2,
  output logic [WIDTH-1:0] salidaand,
  output logic [WIDTH-1:0] salidaor,
  output logic [WIDTH-1:0] salidaxor,
  output logic [WIDTH-1:0] salidanot,
  output logic [WIDTH-1:0] salidanand,
  output logic [WIDTH-1:0] salidayes,
  output logic [WIDTH-1:0] salidanor,
  output logic [WIDTH-1:0] salidaxnor
);

  logic [c_num_ops-1:0][WIDTH-1:0] w_res;
  logic [c_num_ops-1:0][WIDTH-1:0] r_res;

  gate_bank #(
    .WIDTH (WIDTH)
  ) u_gate_bank (
    .a (entrada1),
    .b (entrada2),
    .y (w_res)
  );

  // Reset value is all-zeros for every output, including the inverting gates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res <= '0;
    end else begin
      r_res <= w_res;
    end
  end

  assign salidaand  = r_res[c_op_and];
  assign salidaor   = r_res[c_op_or];
  assign salidaxor  = r_res[c_op_xor];
  assign salidanot  = r_res[c_op_not];
  assign salidanand = r_res[c_op_nand];
  assign salidayes  = r_res[c_op_yes];
  assign salidanor  = r_res[c_op_nor];
  assign salidaxnor = r_res[c_op_xnor];

endmodule

`default_nettype wire

// File: tb/tb_actividad_03.sv
// =============================================================================
// Module  : tb_actividad_03
// Brief   : Self-checking bench for actividad_03 at WIDTH=1 and WIDTH=4
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_actividad_03;
  import actividad_03_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       a1, b1;
  logic [3:0] a4, b4;

  logic [7:0]  got1;
  logic [31:0] got4;

  always #5 clk = ~clk;

  actividad_03 #(.WIDTH(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .entrada1   (a1),
    .entrada2   (b1),
    .salidaand  (got1[0]),
    .salidaor   (got1[1]),
    .salidaxor  (got1[2]),
    .salidanot  (got1[3]),
    .salidanand (got1[4]),
    .salidayes  (got1[5]),
    .salidanor  (got1[6]),
    .salidaxnor (got1[7])
  );

  actividad_03 #(.WIDTH(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .entrada1   (a4),
    .entrada2   (b4),
    .salidaand  (got4[3:0]),
    .salidaor   (got4[7:4]),
    .salidaxor  (got4[11:8]),
    .salidanot  (got4[15:12]),
    .salidanand (got4[19:16]),
    .salidayes  (got4[23:20]),
    .salidanor  (got4[27:24]),
    .salidaxnor (got4[31:28])
  );

  typedef struct {
    logic        rst;
    logic        a1;
    logic        b1;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic [7:0]  exp1;   // {xnor,nor,yes,nand,not,xor,or,and}
    logic [31:0] exp4;   // same order, one nibble per gate
  } vec_t;

  typedef struct {
    logic [7:0]  exp1;
    logic [31:0] exp4;
    string       tag;
  } sb_t;

  sb_t         sbq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          have_last = 1'b0;
  logic [7:0]  last1;
  logic [31:0] last4;
  string       opname[8] = '{"and", "or", "xor", "not", "nand", "yes", "nor", "xnor"};

  function automatic logic [7:0] model1(input logic r, input logic a, input logic b);
    if (r) return '0;
    return {~(a ^ b), ~(a | b), a, ~(a & b), ~a, a ^ b, a | b, a & b};
  endfunction

  function automatic logic [31:0] model4(input logic r, input logic [3:0] a, input logic [3:0] b);
    if (r) return '0;
    return {~(a ^ b), ~(a | b), a, ~(a & b), ~a, a ^ b, a | b, a & b};
  endfunction

  task automatic compare(input string tag, input logic [7:0] e1, input logic [31:0] e4);
    for (int i = 0; i < c_num_ops; i++) begin
      n_tests++;
      if (got1[i] !== e1[i]) begin
        n_fail++;
        $display("FAIL %s w1.%s got=%b exp=%b", tag, opname[i], got1[i], e1[i]);
      end
      n_tests++;
      if (got4[i*4 +: 4] !== e4[i*4 +: 4]) begin
        n_fail++;
        $display("FAIL %s w4.%s got=%b exp=%b", tag, opname[i], got4[i*4 +: 4], e4[i*4 +: 4]);
      end
    end
  endtask

  // Drive between edges, confirm outputs still hold the previous result,
  // then score the new result just after the next rising edge.
  task automatic step(input string tag, input logic r, input logic ia1, input logic ib1,
                      input logic [3:0] ia4, input logic [3:0] ib4,
                      input logic [7:0] e1, input logic [31:0] e4);
    sb_t item;
    rst = r; a1 = ia1; b1 = ib1; a4 = ia4; b4 = ib4;
    item.exp1 = e1; item.exp4 = e4; item.tag = tag;
    sbq.push_back(item);
    #2;
    if (have_last) compare({tag, "_hold"}, last1, last4);
    @(posedge clk);
    #1;
    item = sbq.pop_front();
    compare(item.tag, item.exp1, item.exp4);
    last1 = item.exp1;
    last4 = item.exp4;
    have_last = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec[5];
    logic       ra1, rb1;
    logic [3:0] ra4, rb4;

    vec[0] = '{1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, 8'b0000_0000, 32'h0000_0000};
    vec[1] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'b1101_1000,
               {4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000}};
    vec[2] = '{1'b0, 1'b0, 1'b1, 4'b1100, 4'b1010, 8'b0001_1110,
               {4'b1001, 4'b0001, 4'b1100, 4'b0111, 4'b0011, 4'b0110, 4'b1110, 4'b1000}};
    vec[3] = '{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0101, 8'b0011_0110,
               {4'b0101, 4'b0000, 4'b1111, 4'b1010, 4'b0000, 4'b1010, 4'b1111, 4'b0101}};
    vec[4] = '{1'b0, 1'b1, 1'b1, 4'b0011, 4'b0110, 8'b1010_0011,
               {4'b1010, 4'b1000, 4'b0011, 4'b1101, 4'b1100, 4'b0101, 4'b0111, 4'b0010}};

    for (int i = 0; i < 5; i++) begin
      step($sformatf("vec%0d", i), vec[i].rst, vec[i].a1, vec[i].b1,
           vec[i].a4, vec[i].b4, vec[i].exp1, vec[i].exp4);
    end

    // Mid-run reset with inverting gates high; inputs seen during reset are dropped.
    step("pre_rst", 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, vec[1].exp1, vec[1].exp4);
    step("mid_rst", 1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, 8'h00, 32'h0);
    step("post_rst", 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, vec[1].exp1, vec[1].exp4);
    step("back11", 1'b0, 1'b1, 1'b1, 4'b0011, 4'b0110, vec[4].exp1, vec[4].exp4);

    for (int i = 0; i < 1000; i++) begin
      ra1 = 1'($urandom);
      rb1 = 1'($urandom);
      ra4 = 4'($urandom);
      rb4 = 4'($urandom);
      step("rand", 1'b0, ra1, rb1, ra4, rb4, model1(1'b0, ra1, rb1), model4(1'b0, ra4, rb4));
    end

    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_empty got=%0d exp=0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
